// File: rtl/dpa_pkg.sv
// Shared constants for the DPA1 operand front end.
// Optional feature macro used by the encoder: DPA_ERR_STATS_EN.
package dpa_pkg;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;
    localparam int   FIFO_DEPTH = 2;

endpackage

// File: rtl/dpa_operand_encoder_sm_to_tc.sv
// Sign-magnitude to two's-complement converter with a range check.
// Purely combinational; one instance per operand.
module sm_to_tc #(
    parameter int N = 64
) (
    input  logic [N-1:0] mag,
    input  logic         neg,
    input  logic         signed_in,
    output logic [N-1:0] value,
    output logic         err
);

    // Negate when signed and negative; flag magnitudes the signed range cannot hold.
    always_comb begin
        value = mag;
        err   = 1'b0;
        if (signed_in) begin
            if (neg) begin
                value = ~mag + {{(N-1){1'b0}}, 1'b1};
                // -2^(N-1) is the single legal magnitude with the top bit set
                err   = mag[N-1] & (|mag[N-2:0]);
            end else begin
                err   = mag[N-1];
            end
        end else begin
            // unsigned operands carry the raw magnitude; a sign bit is an error
            err = neg;
        end
    end

endmodule

// File: rtl/dpa_operand_encoder.sv
// Operand encoder for the DPA1 adder: converts sign-magnitude operands and
// an add/sub opcode into two's-complement a/b/cin, behind a 2-entry skid FIFO
// whose head register drives the output ports directly.
// Optional macro DPA_ERR_STATS_EN adds err_clr / err_count (saturating error tally).
module dpa_operand_encoder
    import dpa_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_mag,
    input  logic         a_neg,
    input  logic [N-1:0] b_mag,
    input  logic         b_neg,
    input  logic         op_sub,
    input  logic         signed_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic         signed_en,
    output logic         range_err
`ifdef DPA_ERR_STATS_EN
    ,
    input  logic         err_clr,
    output logic [15:0]  err_count
`endif
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         signed_en;
        logic         range_err;
    } entry_t;

    logic [N-1:0] val_a, val_b;
    logic         err_a, err_b;
    entry_t       nxt_ent, head, tail;
    logic [1:0]   cnt, nxt_cnt;
    logic         push, pop;

    sm_to_tc #(.N(N)) u_cvt_a (.mag(a_mag), .neg(a_neg), .signed_in(signed_in), .value(val_a), .err(err_a));
    sm_to_tc #(.N(N)) u_cvt_b (.mag(b_mag), .neg(b_neg), .signed_in(signed_in), .value(val_b), .err(err_b));

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Build the entry to capture: subtraction is ~B with carry-in 1.
    always_comb begin
        nxt_ent.a         = val_a;
        nxt_ent.b         = (op_sub == OP_SUB) ? ~val_b : val_b;
        nxt_ent.cin       = (op_sub == OP_SUB);
        nxt_ent.signed_en = signed_in;
        nxt_ent.range_err = err_a | err_b;
    end

    // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
    always_comb begin
        nxt_cnt = cnt;
        if (push && !pop)
            nxt_cnt = cnt + 2'd1;
        else if (pop && !push)
            nxt_cnt = cnt - 2'd1;
    end

    // FIFO storage: head feeds the ports, tail absorbs the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            cnt       <= nxt_cnt;
            out_valid <= (nxt_cnt != 2'd0);
            in_ready  <= (nxt_cnt < 2'(FIFO_DEPTH));
            // push into an empty head, or replace a head that is leaving with count 1
            if (push && ((cnt == 2'd0) || (pop && cnt == 2'd1)))
                head <= nxt_ent;
            else if (pop)
                head <= tail;
            if (push && !pop && cnt == 2'd1)
                tail <= nxt_ent;
        end
    end

    assign a         = head.a;
    assign b         = head.b;
    assign cin       = head.cin;
    assign signed_en = head.signed_en;
    assign range_err = head.range_err;

`ifdef DPA_ERR_STATS_EN
    logic [15:0] err_cnt_q;

    // Saturating tally of accepted erroring entries; clear wins but still counts a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= 16'd0;
        else if (err_clr)
            err_cnt_q <= (push && nxt_ent.range_err) ? 16'd1 : 16'd0;
        else if (push && nxt_ent.range_err && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_count = err_cnt_q;
`endif

endmodule
